// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-type codes,
// responder state encoding and the store byte-enable helper.
package dmem_pkg;

  // funct3 access-type codes as driven by the M stage
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Byte lanes touched by an access; only the size bits of funct3 matter
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr;
      2'b01:   be = addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store data replication and byte enables,
// misalignment / illegal-type detection, and load lane select + extension.
module mem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        misalign_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  // Replicate right-aligned store data onto every lane so the enables pick the right one
  always_comb begin
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00:   wdata_o = {4{wdata_i[7:0]}};
      2'b01:   wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

  assign be_o = byte_en(funct3_i, addr_i);

  // Flag reserved access types and accesses that straddle their natural alignment
  always_comb begin
    misalign_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: misalign_o = 1'b0;
      F3_H, F3_HU: misalign_o = addr_i[0];
      F3_W:        misalign_o = (addr_i != 2'b00);
      default:     misalign_o = 1'b1;
    endcase
  end

  assign ldByte = ld_word_i[8*ld_addr_i +: 8];
  assign ldHalf = ld_addr_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

  // Pick the addressed lane of the captured word and sign- or zero-extend it
  always_comb begin
    ld_data_o = ld_word_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ldByte[7]}}, ldByte};
      F3_BU:   ld_data_o = {24'h000000, ldByte};
      F3_H:    ld_data_o = {{16{ldHalf[15]}}, ldHalf};
      F3_HU:   ld_data_o = {16'h0000, ldHalf};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for the M stage: single-cycle stores, loads that
// stall the pipeline for LATENCY cycles before returning extended data.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMemM,
  output logic        MisalignM
);

  localparam int         ADDR_W   = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] word_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic [ADDR_W-1:0] wordIdx;
  logic [31:0]       storeData;
  logic [3:0]        storeBe;
  logic              badAccess;
  logic [31:0]       loadData;
  logic              legalReq;
  logic              storeEn;
  logic              loadStart;
  logic              loadDone;
  logic              unusedAddr;

  // Addresses wrap modulo the array size; the high bits are deliberately dropped
  assign wordIdx    = ALUResultM[ADDR_W+1:2];
  assign unusedAddr = ^ALUResultM[31:ADDR_W+2];

  mem_align u_align (
    .funct3_i    (funct3M),
    .addr_i      (ALUResultM[1:0]),
    .wdata_i     (WriteDataM),
    .wdata_o     (storeData),
    .be_o        (storeBe),
    .misalign_o  (badAccess),
    .ld_funct3_i (f3_q),
    .ld_addr_i   (off_q),
    .ld_word_i   (word_q),
    .ld_data_o   (loadData)
  );

  assign legalReq  = MemReqM && !badAccess && (state_q == IDLE);
  assign storeEn   = legalReq && MemWriteM && !reset;
  assign loadStart = legalReq && !MemWriteM;
  assign loadDone  = (state_q == WAIT) && (cnt_q == 4'd0);

  assign StallMemM = !reset && (loadStart || ((state_q == WAIT) && (cnt_q != 4'd0)));
  assign ReadDataM = (!reset && loadDone) ? loadData : 32'h0000_0000;
  assign MisalignM = !reset && MemReqM && badAccess;

  // Next-state logic: a legal load arms the countdown, WAIT drains it then retires
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (loadStart) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and countdown registers, cleared by reset so an in-flight load is abandoned
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the addressed word and access details when a load is accepted
  always_ff @(posedge clk) begin
    if (!reset && loadStart) begin
      word_q <= mem[wordIdx];
      f3_q   <= funct3M;
      off_q  <= ALUResultM[1:0];
    end
  end

  // Lane-masked array write; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (storeEn) begin
      for (int i = 0; i < 4; i++) begin
        if (storeBe[i]) begin
          mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios plus randomized
// loads/stores against a byte-addressed reference memory.
module tb_dmem_resp;

  localparam int DEPTH   = 1024;
  localparam int LAT     = 2;
  localparam int NBYTES  = DEPTH * 4;
  localparam int MAXWAIT = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        memReq, memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] readData;
  logic        stall, misalign;

  logic        reqB, writeB;
  logic [2:0]  funct3B;
  logic [31:0] addrB, wdataB;
  logic [31:0] readDataB;
  logic        stallB, misalignB;

  int checks = 0;
  int errors = 0;

  logic [7:0] refMem [NBYTES];

  dmem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReqM    (memReq),
    .MemWriteM  (memWrite),
    .funct3M    (funct3),
    .ALUResultM (addr),
    .WriteDataM (wdata),
    .ReadDataM  (readData),
    .StallMemM  (stall),
    .MisalignM  (misalign)
  );

  dmem_resp #(.DEPTH(64), .LATENCY(1)) dutLat1 (
    .clk        (clk),
    .reset      (reset),
    .MemReqM    (reqB),
    .MemWriteM  (writeB),
    .funct3M    (funct3B),
    .ALUResultM (addrB),
    .WriteDataM (wdataB),
    .ReadDataM  (readDataB),
    .StallMemM  (stallB),
    .MisalignM  (misalignB)
  );

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic modelErr(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return a[0];
      3'd2:       return (a[1:0] != 2'b00);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic int byteIndex(input logic [31:0] a);
    return int'(a % 32'(NBYTES));
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a);
    int ix;
    int base;
    logic [7:0]  b;
    logic [15:0] h;
    ix   = byteIndex(a);
    base = ix - (ix % 4);
    b    = refMem[ix];
    h    = {refMem[ix+1], refMem[ix]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'h000000, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0000, h};
      default: return {refMem[base+3], refMem[base+2], refMem[base+1], refMem[base]};
    endcase
  endfunction

  task automatic modelStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int ix;
    ix = byteIndex(a);
    case (f3)
      3'd0: refMem[ix] = wd[7:0];
      3'd1: begin
        refMem[ix]   = wd[7:0];
        refMem[ix+1] = wd[15:8];
      end
      default: begin
        refMem[ix]   = wd[7:0];
        refMem[ix+1] = wd[15:8];
        refMem[ix+2] = wd[23:16];
        refMem[ix+3] = wd[31:24];
      end
    endcase
  endtask

  // One M-stage access on the main instance; called #1 after a rising edge
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic useExp, input logic [31:0] expIn);
    logic        err;
    logic [31:0] exp;
    int          n;
    err      = modelErr(f3, a);
    memReq   = 1'b1;
    memWrite = we;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    @(negedge clk);
    checkOutput("misalign", 32'(misalign), 32'(err));
    if (err || we) begin
      checkOutput(err ? "errStall" : "storeStall", 32'(stall), 32'd0);
      checkOutput(err ? "errRead" : "storeRead", readData, 32'd0);
      @(posedge clk);
      if (!err) modelStore(f3, a, wd);
    end else begin
      exp = useExp ? expIn : modelLoad(f3, a);
      n = 0;
      while (stall && n < MAXWAIT) begin
        checkOutput("loadBusyRead", readData, 32'd0);
        n++;
        @(posedge clk);
        @(negedge clk);
      end
      checkOutput("loadStallCycles", 32'(n), 32'(LAT));
      checkOutput("loadData", readData, exp);
      @(posedge clk);
    end
    #1;
    memReq   = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    checkOutput("idleStall", 32'(stall), 32'd0);
    checkOutput("idleRead", readData, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        we;

    reset = 1'b1;
    memReq = 1'b0; memWrite = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
    reqB = 1'b0; writeB = 1'b0; funct3B = 3'd0; addrB = '0; wdataB = '0;
    repeat (2) @(posedge clk);
    #1;

    // A legal load presented during reset must not stall or return data
    memReq = 1'b1; funct3 = 3'd2; addr = 32'h10;
    @(negedge clk);
    checkOutput("resetStall", 32'(stall), 32'd0);
    checkOutput("resetRead", readData, 32'd0);
    checkOutput("resetMisalign", 32'(misalign), 32'd0);
    checkOutput("resetStallB", 32'(stallB), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    memReq = 1'b0;

    // Known contents for the low 64 bytes used by the random phase
    for (int w = 0; w < 16; w++) begin
      applyStimulus(1'b1, 3'd2, 32'(w * 4), $urandom, 1'b0, 32'd0);
    end

    applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
    applyStimulus(1'b0, 3'd0, 32'h11, 32'd0, 1'b1, 32'hFFFFFFBE);
    idleCycle();
    applyStimulus(1'b0, 3'd4, 32'h13, 32'd0, 1'b1, 32'h000000DE);
    applyStimulus(1'b0, 3'd5, 32'h12, 32'd0, 1'b1, 32'h0000DEAD);
    applyStimulus(1'b0, 3'd1, 32'h10, 32'd0, 1'b1, 32'hFFFFBEEF);
    applyStimulus(1'b1, 3'd1, 32'h12, 32'h00001234, 1'b0, 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h1234BEEF);
    applyStimulus(1'b1, 3'd0, 32'h10, 32'h00000077, 1'b0, 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h1234BE77);
    applyStimulus(1'b0, 3'd2, 32'h02, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b1, 3'd1, 32'h11, 32'h0000FFFF, 1'b0, 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h1234BE77);
    applyStimulus(1'b0, 3'd2, 32'(NBYTES + 32'h10), 32'd0, 1'b1, 32'h1234BE77);
    applyStimulus(1'b0, 3'd3, 32'h10, 32'd0, 1'b0, 32'd0);

    // Reset while waiting abandons the load; a store under reset must not land
    memReq = 1'b1; memWrite = 1'b0; funct3 = 3'd2; addr = 32'h10;
    @(negedge clk);
    checkOutput("abortLoadStall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1; memWrite = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("abortResetStall", 32'(stall), 32'd0);
    checkOutput("abortResetRead", readData, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; memReq = 1'b0; memWrite = 1'b0;
    idleCycle();
    applyStimulus(1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h1234BE77);

    // Randomized accesses within the initialized window, with random high address bits
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      if (we) begin
        case ($urandom_range(0, 4))
          0:       f3 = 3'd0;
          1:       f3 = 3'd1;
          2:       f3 = 3'd2;
          3:       f3 = 3'd3;
          default: f3 = 3'd6;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      applyStimulus(we, f3, a, $urandom, 1'b0, 32'd0);
    end

    // Single-cycle-latency instance: back-to-back loads give stall 1,0,1,0
    reqB = 1'b1; writeB = 1'b1; funct3B = 3'd2; addrB = 32'h10; wdataB = 32'h11112222;
    @(posedge clk);
    #1;
    addrB = 32'h14; wdataB = 32'h33334444;
    @(posedge clk);
    #1;
    writeB = 1'b0; addrB = 32'h10;
    @(negedge clk);
    checkOutput("lat1Stall1", 32'(stallB), 32'd1);
    checkOutput("lat1Read1", readDataB, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("lat1Stall2", 32'(stallB), 32'd0);
    checkOutput("lat1Read2", readDataB, 32'h11112222);
    @(posedge clk);
    #1;
    addrB = 32'h14;
    @(negedge clk);
    checkOutput("lat1Stall3", 32'(stallB), 32'd1);
    checkOutput("lat1Read3", readDataB, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("lat1Stall4", 32'(stallB), 32'd0);
    checkOutput("lat1Read4", readDataB, 32'h33334444);
    @(posedge clk);
    #1;
    reqB = 1'b0;
    @(negedge clk);
    checkOutput("lat1IdleRead", readDataB, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
